// File: rtl/hello_world_qsys_keys_in.sv
// Debounced key/switch input port with edge capture and level irq.
// Avalon-MM slave: data, reserved, irq_mask, edge_capture.
module hello_world_qsys_keys_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_nx;
  logic [WIDTH-1:0] irq_mask, edge_capture, edge_nx;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic [15:0]      cnt    [WIDTH];
  logic [15:0]      cnt_nx [WIDTH];
  logic             wr, rd;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign unused_wd = &{1'b0, writedata};

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;

  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nx[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX)
          stable_nx[i] = sync2[i];
        else
          cnt_nx[i] = cnt[i] + 16'd1;
      end
    end
  end

  assign rise = stable_nx & ~stable;
  assign fall = stable & ~stable_nx;

  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  // a new event wins over a same-cycle clear
  assign clr     = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign edge_nx = (edge_capture & ~clr) | ev;

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = 32'(stable);
      2'd1: rd_mux = '0;
      2'd2: rd_mux = 32'(irq_mask);
      2'd3: rd_mux = 32'(edge_capture);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      stable       <= '0;
      cnt          <= '{default: '0};
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      sync1        <= in_port;
      sync2        <= sync1;
      stable       <= stable_nx;
      cnt          <= cnt_nx;
      edge_capture <= edge_nx;
      irq          <= |(edge_capture & irq_mask);
      if (wr && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      if (rd)
        readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hello_world_qsys_keys_in.sv
// Bench for hello_world_qsys_keys_in: directed sequences, a register
// table and randomized traffic against a sample-history reference model.
module tb_hello_world_qsys_keys_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  hello_world_qsys_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd0), .irq(irq0));

  hello_world_qsys_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd1), .irq(irq1));

  hello_world_qsys_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd2), .irq(irq2));

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per instance
  int          dcp [3] = '{16, 16, 3};
  int          etp [3] = '{0, 1, 2};
  logic [3:0]  m_st [3];
  logic [3:0]  m_mask [3];
  logic [3:0]  m_cap [3];
  logic [31:0] m_rd [3];
  logic        m_irq [3];
  logic [3:0]  ph1 = '0;
  logic [3:0]  ph2 = '0;
  logic [3:0]  hist [$];

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  // a pin value is accepted once the last dc synchronized samples all
  // disagree with the current debounced value
  function automatic bit accepted(int dc, int b, logic cur);
    int n = hist.size();
    if (n < dc) return 0;
    for (int k = n - dc; k < n; k++)
      if (hist[k][b] == cur) return 0;
    return 1;
  endfunction

  task automatic model_step();
    logic [3:0] nst, ev, clr;
    bit wr, rd;
    wr = chipselect && !write_n;
    rd = chipselect && !read_n;
    if (reset) begin
      hist.delete();
    end else begin
      hist.push_back(ph2);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_st[i] = '0; m_mask[i] = '0; m_cap[i] = '0;
        m_rd[i] = '0; m_irq[i] = 1'b0;
      end else begin
        nst = m_st[i];
        for (int b = 0; b < 4; b++)
          if (accepted(dcp[i], b, m_st[i][b])) nst[b] = ~m_st[i][b];
        case (etp[i])
          0:       ev = nst & ~m_st[i];
          1:       ev = ~nst & m_st[i];
          default: ev = nst ^ m_st[i];
        endcase
        if (rd)
          case (address)
            2'd0: m_rd[i] = {28'd0, m_st[i]};
            2'd1: m_rd[i] = '0;
            2'd2: m_rd[i] = {28'd0, m_mask[i]};
            default: m_rd[i] = {28'd0, m_cap[i]};
          endcase
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        clr = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
        m_cap[i] = (m_cap[i] & ~clr) | ev;
        if (wr && address == 2'd2) m_mask[i] = writedata[3:0];
        m_st[i] = nst;
      end
    end
    ph2 = reset ? 4'd0 : ph1;
    ph1 = reset ? 4'd0 : in_port;
  endtask

  task automatic tick();
    logic [31:0] r [3];
    logic        q [3];
    @(posedge clk);
    model_step();
    #1;
    r = '{rd0, rd1, rd2};
    q = '{irq0, irq1, irq2};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_readdata_u%0d", i), r[i], m_rd[i]);
      chk($sformatf("model_irq_u%0d", i), {31'd0, q[i]}, {31'd0, m_irq[i]});
    end
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
    address = a; writedata = d;
    tick();
    idle();
  endtask

  task automatic bus_read(logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
    address = a;
    tick();
    idle();
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd2, 32'h0000_0005, 32'h0};
    tbl[1] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    tbl[2] = '{1'b0, 2'd0, 32'h0, 32'hA};
    tbl[3] = '{1'b0, 2'd1, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 2'd2, 32'h0, 32'h5};
    tbl[5] = '{1'b0, 2'd3, 32'h0, 32'h3};
    tbl[6] = '{1'b0, 2'd3, 32'h0, 32'h3};
    tbl[7] = '{1'b1, 2'd2, 32'hFFFF_FFF0, 32'h0};
    tbl[8] = '{1'b0, 2'd2, 32'h0, 32'h0};

    // reset state
    reset = 1'b1;
    ticks(3);
    chk("reset_readdata", rd0, 32'h0);
    chk("reset_irq", {31'd0, irq0}, 32'h0);
    reset = 1'b0;
    ticks(2);

    // clean rise on bit 0: stable changes on the 18th edge
    in_port = 4'h1;
    ticks(17);
    bus_read(2'd0);
    chk("latency_edge18_pre", rd0, 32'h0);
    bus_read(2'd0);
    chk("latency_edge19_post", rd0, 32'h1);
    bus_read(2'd3);
    chk("rise_capture_et0", rd0, 32'h1);
    chk("rise_ignored_et1", rd1, 32'h0);

    // 10-cycle glitch on bit 1 is rejected
    bus_write(2'd3, 32'hF);
    in_port = 4'h3;
    ticks(10);
    in_port = 4'h1;
    ticks(30);
    bus_read(2'd0);
    chk("glitch_data_et0", rd0, 32'h1);
    chk("glitch_data_et1", rd1, 32'h1);
    bus_read(2'd3);
    chk("glitch_cap_et0", rd0, 32'h0);
    chk("glitch_cap_et1", rd1, 32'h0);
    chk("glitch_irq", {31'd0, irq0}, 32'h0);

    // falling edge on bit 2 with mask 0x4
    in_port = 4'h5;
    ticks(25);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h4);
    in_port = 4'h1;
    ticks(17);
    chk("irq_before_edge", {31'd0, irq1}, 32'h0);
    tick();
    chk("irq_on_capture_edge", {31'd0, irq1}, 32'h0);
    tick();
    chk("irq_one_after_capture", {31'd0, irq1}, 32'h1);
    chk("irq_et0_no_fall", {31'd0, irq0}, 32'h0);
    bus_read(2'd3);
    chk("fall_capture_et1", rd1, 32'h4);
    bus_write(2'd3, 32'h4);
    chk("irq_on_clear_edge", {31'd0, irq1}, 32'h1);
    tick();
    chk("irq_after_clear", {31'd0, irq1}, 32'h0);
    bus_read(2'd3);
    chk("cap_after_clear", rd1, 32'h0);

    // event on bit 3 coincides with a clear-all write
    in_port = 4'h9;
    ticks(17);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3);
    chk("set_beats_clear_et0", rd0, 32'h8);
    chk("clear_et1", rd1, 32'h0);

    // build stable=0xA, edge_capture=0x3 on the falling-edge instance
    in_port = 4'hB;
    ticks(20);
    bus_write(2'd3, 32'hF);
    in_port = 4'h8;
    ticks(20);
    in_port = 4'hA;
    ticks(20);
    for (int k = 0; k < 9; k++) begin
      if (tbl[k].wr) begin
        bus_write(tbl[k].addr, tbl[k].wd);
      end else begin
        bus_read(tbl[k].addr);
        chk($sformatf("table_%0d_addr%0d", k, tbl[k].addr), rd1, tbl[k].exp);
      end
    end
    address = 2'd0;
    ticks(3);
    chk("readdata_hold", rd1, 32'h0);

    // reset mid-debounce discards the partial count
    in_port = 4'h5;
    ticks(10);
    reset = 1'b1;
    tick();
    chk("midreset_rd_u0", rd0, 32'h0);
    chk("midreset_rd_u1", rd1, 32'h0);
    chk("midreset_irq_u1", {31'd0, irq1}, 32'h0);
    reset = 1'b0;
    ticks(17);
    bus_read(2'd0);
    chk("postreset_edge18_pre", rd0, 32'h0);
    bus_read(2'd0);
    chk("postreset_edge19_post", rd0, 32'h5);
    bus_read(2'd3);
    chk("postreset_rise_cap", rd0, 32'h5);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) in_port = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      chipselect = ($urandom_range(0, 2) == 0);
      read_n = $urandom_range(0, 1) == 0;
      write_n = $urandom_range(0, 3) != 0;
      address = 2'($urandom);
      writedata = $urandom;
      tick();
    end
    reset = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
